mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that acts as a responder on the core's data-memory bus, alongside the data RAM, in its own address window. The core writes bytes to a TXDATA register. They queue in a small FIFO and are serialised 8N1, LSB first, on `tx` at a programmable bit period. Reads return status and configuration combinationally, with the same zero-wait-state read timing as the data RAM.

---
 rtl/mmio_uart_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/mmio_uart_tx.sv | 177 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register word offsets within the 16-byte window, STATUS bit positions,
// and the transmit FSM state encoding.
package mmio_uart_pkg;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_BAUDDIV = 2'd2;

  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_BUSY      = 2;
  localparam int unsigned ST_OVF       = 3;
  localparam int unsigned ST_COUNT_LSB = 8;
  localparam int unsigned ST_COUNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, wr_data   : write request and data (ignored when full)
//   pop, rd_data    : read request (ignored when empty); rd_data is the head entry
//   full, empty     : occupancy flags
//   count           : number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   Addr       : byte address; 16-byte window at BASE_ADDR
//   WD, BE, WE : write data, byte enables, write strobe
//   read_data  : combinational read data (0 outside the window)
//   tx         : serial output, idles high
// Registers: +0 TXDATA (W), +4 STATUS (R, W1C overflow via bit3), +8 BAUDDIV (R/W).
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic [3:0]  BE,
  input  logic        WE,
  output logic [31:0] read_data,
  output logic        tx
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic            hit;
  logic [1:0]      off;
  logic            push_req;
  logic            ovf_clr;
  logic            bd_wr;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic [7:0]      head;
  logic            pop;
  logic            overflow;
  logic [15:0]     bauddiv;

  tx_state_t       state, state_nx;
  logic [15:0]     timer, timer_nx;
  logic [2:0]      bitcnt, bitcnt_nx;
  logic [7:0]      shift, shift_nx;
  logic            bit_end;

  logic            unused_bits;
  assign unused_bits = ^{Addr[1:0], WD[31:16], BE[3:2]};

  assign hit      = (Addr[31:4] == BASE_ADDR[31:4]);
  assign off      = Addr[3:2];
  assign push_req = WE && hit && (off == OFF_TXDATA) && BE[0];
  assign ovf_clr  = WE && hit && (off == OFF_STATUS) && BE[0] && WD[3];
  assign bd_wr    = WE && hit && (off == OFF_BAUDDIV);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_req),
    .wr_data (WD[7:0]),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // A push into a full FIFO is lost even if a pop frees a slot on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      bauddiv  <= DIV_RESET;
    end else begin
      if (push_req && full) overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
      if (bd_wr && BE[0]) bauddiv[7:0]  <= WD[7:0];
      if (bd_wr && BE[1]) bauddiv[15:8] <= WD[15:8];
    end
  end

  always_comb begin
    read_data = '0;
    if (hit) begin
      case (off)
        OFF_STATUS: begin
          read_data[ST_FULL]  = full;
          read_data[ST_EMPTY] = empty;
          read_data[ST_BUSY]  = (state != IDLE);
          read_data[ST_OVF]   = overflow;
          read_data[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(count);
        end
        OFF_BAUDDIV: read_data[15:0] = bauddiv;
        default: ;
      endcase
    end
  end

  assign bit_end = (timer == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      timer  <= '0;
      bitcnt <= '0;
      shift  <= '0;
    end else begin
      state  <= state_nx;
      timer  <= timer_nx;
      bitcnt <= bitcnt_nx;
      shift  <= shift_nx;
    end
  end

  // tx decodes directly from state so an asynchronous reset forces it high at once.
  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    bitcnt_nx = bitcnt;
    shift_nx  = shift;
    pop       = 1'b0;
    tx        = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          shift_nx = head;
          timer_nx = bauddiv;
          state_nx = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) begin
          timer_nx  = bauddiv;
          bitcnt_nx = '0;
          state_nx  = DATA;
        end else begin
          timer_nx = timer - 16'd1;
        end
      end
      DATA: begin
        tx = shift[0];
        if (bit_end) begin
          timer_nx = bauddiv;
          if (bitcnt == 3'd7) begin
            state_nx = STOP;
          end else begin
            bitcnt_nx = bitcnt + 3'd1;
            shift_nx  = {1'b0, shift[7:1]};
          end
        end else begin
          timer_nx = timer - 16'd1;
        end
      end
      STOP: begin
        tx = 1'b1;
        if (bit_end) begin
          if (!empty) begin
            pop      = 1'b1;
            shift_nx = head;
            timer_nx = bauddiv;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          timer_nx = timer - 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed scenarios plus randomized
// traffic compared cycle by cycle against a frame-level reference model.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int unsigned DEPTH = 8;
  localparam logic [15:0] DIVR  = 16'd433;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'd4;
  localparam logic [31:0] A_BD  = BASE + 32'd8;
  localparam logic [31:0] A_R3  = BASE + 32'hC;
  localparam logic [31:0] A_OUT = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WD = '0;
  logic [3:0]  BE = '0;
  logic        WE = 1'b0;
  logic [31:0] read_data;
  logic        tx;

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .DIV_RESET  (DIVR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Addr      (Addr),
    .WD        (WD),
    .BE        (BE),
    .WE        (WE),
    .read_data (read_data),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: byte queue, sticky overflow, divider, and the frame in flight
  // described by its byte, its divider, and the clocks it still has to run.
  logic [7:0]  mq[$];
  logic        m_ovf;
  logic [15:0] m_div;
  int unsigned frame_left;
  int unsigned cur_div;
  logic [7:0]  cur_byte;
  bit          use_model;
  int unsigned busy_cycles;
  logic        tx_log[$];
  logic [31:0] base_v;

  task automatic model_reset();
    mq.delete();
    m_ovf      = 1'b0;
    m_div      = DIVR;
    frame_left = 0;
    cur_div    = 0;
    cur_byte   = '0;
  endtask

  function automatic logic exp_tx();
    int unsigned p, b;
    if (frame_left == 0) return 1'b1;
    p = 10 * (cur_div + 1) - frame_left;
    b = p / (cur_div + 1);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur_byte[b-1];
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s      = '0;
    s[0]   = (mq.size() == DEPTH);
    s[1]   = (mq.size() == 0);
    s[2]   = (frame_left != 0);
    s[3]   = m_ovf;
    s[12:8] = 5'(mq.size());
    return s;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    if (a[31:4] != base_v[31:4]) return '0;
    case (a[3:2])
      2'd1:    return exp_status();
      2'd2:    return {16'h0, m_div};
      default: return '0;
    endcase
  endfunction

  task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b);
    int unsigned sz;
    sz = mq.size();
    if (sz > 0 && frame_left <= 1) begin
      cur_byte   = mq.pop_front();
      cur_div    = m_div;
      frame_left = 10 * (cur_div + 1);
    end else if (frame_left > 0) begin
      frame_left--;
    end
    if (w && a[31:4] == base_v[31:4]) begin
      case (a[3:2])
        2'd0: if (b[0]) begin
          if (sz == DEPTH) m_ovf = 1'b1;
          else mq.push_back(d[7:0]);
        end
        2'd1: if (b[0] && d[3]) m_ovf = 1'b0;
        2'd2: begin
          if (b[0]) m_div[7:0]  = d[7:0];
          if (b[1]) m_div[15:8] = d[15:8];
        end
        default: ;
      endcase
    end
  endtask

  // One clock: drive a bus cycle, let the edge happen, then read address ra and check.
  task automatic cyc(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] ra);
    WE = w; Addr = a; WD = d; BE = b;
    model_edge(w, a, d, b);
    @(posedge clk);
    #1;
    WE = 1'b0; Addr = ra; WD = '0; BE = '0;
    #1;
    if (use_model) begin
      check("tx", {31'b0, tx}, {31'b0, exp_tx()});
      check("read", read_data, exp_read(ra));
    end
    if (ra == A_ST && read_data[2]) busy_cycles++;
    tx_log.push_back(tx);
  endtask

  task automatic idle();
    cyc(1'b0, A_ST, '0, 4'b0000, A_ST);
  endtask

  task automatic drain(input int unsigned limit);
    int unsigned n;
    n = 0;
    while ((mq.size() != 0 || frame_left != 0) && n < limit) begin
      idle();
      n++;
    end
    if (n >= limit) check("drain_timeout", n, limit - 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    WE = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        exp_q[$];
    logic [7:0]  pat;
    int unsigned dur;
    int unsigned r;
    logic [31:0] ra;

    base_v    = BASE;
    use_model = 1'b1;
    model_reset();

    // Reset values
    #12;
    Addr = A_ST; #1; check("rst_status", read_data, 32'h0000_0002);
    check("rst_tx", {31'b0, tx}, 32'h1);
    Addr = A_BD; #1; check("rst_baud", read_data, {16'h0, DIVR});
    Addr = A_TX; #1; check("rst_txdata", read_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single 0xA5 frame at BAUDDIV=3
    busy_cycles = 0;
    cyc(1'b1, A_BD, 32'd3, 4'b0011, A_ST);
    cyc(1'b1, A_TX, 32'hA5, 4'b0001, A_ST);
    drain(200);
    check("a5_busy_clocks", busy_cycles, 32'd40);
    check("a5_idle_status", read_data, 32'h0000_0002);

    // Nine back-to-back writes at BAUDDIV=0: first pop frees room, no overflow
    do_reset();
    cyc(1'b1, A_BD, 32'd0, 4'b0011, A_ST);
    for (int unsigned i = 1; i <= 9; i++) cyc(1'b1, A_TX, i, 4'b0001, A_ST);
    check("nine_no_ovf", {31'b0, read_data[3]}, 32'h0);
    check("nine_count", {27'b0, read_data[12:8]}, 32'd8);
    drain(300);

    // Stalled transmitter: the tenth write overflows, then clear it
    do_reset();
    cyc(1'b1, A_BD, 32'h40, 4'b0011, A_ST);
    for (int unsigned i = 1; i <= 10; i++) cyc(1'b1, A_TX, 32'h10 + i, 4'b0001, A_ST);
    check("ovf_set", {31'b0, read_data[3]}, 32'h1);
    check("ovf_full", {31'b0, read_data[0]}, 32'h1);
    cyc(1'b1, A_ST, 32'h8, 4'b0001, A_ST);
    check("ovf_clear", {31'b0, read_data[3]}, 32'h0);

    // Two frames with no idle gap at BAUDDIV=1
    do_reset();
    busy_cycles = 0;
    cyc(1'b1, A_BD, 32'd1, 4'b0011, A_ST);
    cyc(1'b1, A_TX, 32'h00, 4'b0001, A_ST);
    cyc(1'b1, A_TX, 32'hFF, 4'b0001, A_ST);
    drain(200);
    check("b2b_busy_clocks", busy_cycles, 32'd40);

    // BAUDDIV 1 -> 7 written during data bit 2 of a 0x55 frame
    do_reset();
    cyc(1'b1, A_BD, 32'd1, 4'b0011, A_ST);
    use_model = 1'b0;
    tx_log.delete();
    cyc(1'b1, A_TX, 32'h55, 4'b0001, A_ST);
    for (int unsigned i = 0; i < 7; i++) idle();
    cyc(1'b1, A_BD, 32'd7, 4'b0011, A_ST);
    for (int unsigned i = 0; i < 50; i++) idle();
    pat = 8'h55;
    exp_q.push_back(1'b1);
    repeat (2) exp_q.push_back(1'b0);
    for (int unsigned i = 0; i < 8; i++) begin
      dur = (i < 3) ? 2 : 8;
      repeat (dur) exp_q.push_back(pat[i]);
    end
    repeat (10) exp_q.push_back(1'b1);
    check("midbaud_len", tx_log.size(), exp_q.size());
    for (int unsigned i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      check($sformatf("midbaud_tx[%0d]", i), {31'b0, tx_log[i]}, {31'b0, exp_q[i]});
    check("midbaud_busy_end", {31'b0, read_data[2]}, 32'h0);
    do_reset();
    use_model = 1'b1;

    // Asynchronous reset in the middle of the data bits
    cyc(1'b1, A_BD, 32'd3, 4'b0011, A_ST);
    cyc(1'b1, A_TX, 32'h00, 4'b0001, A_ST);
    for (int unsigned i = 0; i < 6; i++) idle();
    check("pre_rst_tx", {31'b0, tx}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_tx_async", {31'b0, tx}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    Addr = A_ST; #1; check("post_rst_status", read_data, 32'h0000_0002);
    Addr = A_BD; #1; check("post_rst_baud", read_data, {16'h0, DIVR});

    // Window decode and byte lanes
    cyc(1'b0, A_ST, '0, 4'b0000, A_R3);
    check("rd_off3", read_data, 32'h0);
    cyc(1'b0, A_ST, '0, 4'b0000, A_OUT);
    check("rd_outside", read_data, 32'h0);
    cyc(1'b1, A_TX, 32'h0000_0077, 4'b0010, A_ST);
    check("be1_nopush", read_data, 32'h0000_0002);
    cyc(1'b1, A_OUT, 32'h0000_0033, 4'b1111, A_ST);
    check("miss_nopush", read_data, 32'h0000_0002);
    cyc(1'b1, A_BD, 32'h0000_1200, 4'b0010, A_BD);
    check("baud_hi_only", read_data, 32'h0000_12B1);

    // Randomized traffic at several dividers
    do_reset();
    for (int unsigned round = 0; round < 6; round++) begin
      drain(3000);
      cyc(1'b1, A_BD, $urandom_range(0, 4), 4'b0011, A_ST);
      for (int unsigned k = 0; k < 200; k++) begin
        r  = $urandom_range(0, 9);
        case ($urandom_range(0, 5))
          0:       ra = A_TX;
          1:       ra = A_BD;
          2:       ra = A_R3;
          3:       ra = A_OUT;
          default: ra = A_ST;
        endcase
        if (r <= 2)
          cyc(1'b1, A_TX, $urandom, 4'($urandom), ra);
        else if (r == 3)
          cyc(1'b1, A_ST, $urandom, 4'($urandom), ra);
        else if (r == 4)
          cyc(1'b1, BASE + 32'h100 + 32'($urandom_range(0, 15)), $urandom, 4'hF, ra);
        else
          cyc(1'b0, A_ST, '0, 4'b0000, ra);
      end
    end
    drain(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
